// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width; a one-bit operand still needs a one-bit counter.
    function automatic int CNT_W(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// One-bit full adder assembled from two half-adder stages.
module serial_adder_fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s1;
    logic c1;
    logic c2;

    assign s1 = a ^ b;
    assign c1 = a & b;
    assign s  = s1 ^ ci;
    assign c2 = s1 & ci;
    assign co = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one full-adder cell reused LSB first, with
// valid/ready handshakes on both the operand and the result side.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);

    localparam int            CW   = CNT_W(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  sum_sh;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          s_bit;
    logic          c_bit;

    serial_adder_fa_bit u_fa_bit (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (s_bit),
        .co (c_bit)
    );

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Shifting the new bit in from the top works for W=1 too.
                    sum_sh <= W'({s_bit, sum_sh} >> 1);
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= c_bit;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_sh;
    assign cout      = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder at W=8 and W=1.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       busy;

    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       out_valid1;
    logic       out_ready1;
    logic [0:0] sum1;
    logic       cout1;
    logic       busy1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    serial_adder #(.W(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1),
        .busy      (busy1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands and hold them until the accept edge has passed.
    task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        int k;
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            step();
            k++;
        end
        check("accept_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    // Cycles from just after the accept edge until out_valid rises.
    task automatic wait_done(output int cycles, output logic saw_ready);
        cycles    = 0;
        saw_ready = in_ready;
        while (!out_valid && cycles < 50) begin
            step();
            cycles++;
            saw_ready = saw_ready | in_ready;
        end
    endtask

    initial begin
        int          cycles;
        logic        saw_ready;
        int          got_n;
        int          hs_total;
        int          k;
        logic        hs;
        logic [8:0]  res;
        logic [8:0]  exp;
        logic [7:0]  av;
        logic [7:0]  bv;
        logic        cv;

        rst        = 1'b1;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        a1         = '0;
        b1         = '0;
        cin1       = 1'b0;
        out_ready1 = 1'b0;

        step();
        step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", cout, 0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", in_ready, 1);

        // 1: FF + 01 wraps to 00 with carry out, 8 cycles after accept.
        send(8'hFF, 8'h01, 1'b0);
        check("t1_busy", busy, 1);
        wait_done(cycles, saw_ready);
        check("t1_latency", cycles, 8);
        check("t1_sum", sum, 8'h00);
        check("t1_cout", cout, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t1_out_valid_drop", out_valid, 0);
        check("t1_in_ready_back", in_ready, 1);

        // 2: A5 + 5A + 1 = 0x100; in_ready low for the whole operation.
        send(8'hA5, 8'h5A, 1'b1);
        wait_done(cycles, saw_ready);
        check("t2_in_ready_run", saw_ready, 0);
        check("t2_in_ready_done", in_ready, 0);
        check("t2_sum", sum, 8'h00);
        check("t2_cout", cout, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t2_in_ready_after", in_ready, 1);

        // 3: backpressure with a competing request held on in_valid.
        send(8'h3C, 8'h42, 1'b0);
        wait_done(cycles, saw_ready);
        check("t3_latency", cycles, 8);
        a        = 8'h11;
        b        = 8'h22;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_hold_valid", out_valid, 1);
            check("t3_hold_sum", sum, 8'h7E);
            check("t3_hold_cout", cout, 0);
            check("t3_hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t3_release", out_valid, 0);
        check("t3_no_second_accept", busy, 0);

        // 4: reset in the third RUN cycle aborts the add.
        send(8'h12, 8'h34, 1'b1);
        step();
        step();
        rst = 1'b1;
        step();
        check("t4_busy", busy, 0);
        check("t4_sum", sum, 8'h00);
        check("t4_cout", cout, 0);
        check("t4_out_valid", out_valid, 0);
        check("t4_in_ready_in_rst", in_ready, 0);
        rst = 1'b0;
        step();
        check("t4_in_ready", in_ready, 1);
        saw_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            saw_ready = saw_ready | out_valid;
        end
        check("t4_no_stale_result", saw_ready, 0);

        // 5: single-bit instance, 1 + 1 + 1 = 0b11.
        a1        = 1'b1;
        b1        = 1'b1;
        cin1      = 1'b1;
        in_valid1 = 1'b1;
        check("t5_in_ready", in_ready1, 1);
        step();
        in_valid1 = 1'b0;
        check("t5_not_yet", out_valid1, 0);
        step();
        check("t5_out_valid", out_valid1, 1);
        check("t5_sum", sum1, 1);
        check("t5_cout", cout1, 1);
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        check("t5_release", out_valid1, 0);

        // 6: random operands with random input gaps and output stalls.
        hs_total = 0;
        for (int t = 0; t < 500; t++) begin
            av  = 8'($urandom);
            bv  = 8'($urandom);
            cv  = 1'($urandom_range(0, 1));
            exp = {1'b0, av} + {1'b0, bv} + {8'h00, cv};
            repeat ($urandom_range(0, 3)) step();
            send(av, bv, cv);
            got_n = 0;
            k     = 0;
            while (got_n == 0 && k < 100) begin
                out_ready = 1'($urandom_range(0, 1));
                hs  = out_valid && out_ready;
                res = {cout, sum};
                step();
                k++;
                if (hs) begin
                    got_n++;
                    check("rand_result", res, exp);
                end
            end
            out_ready = 1'b0;
            hs_total += got_n;
            check("rand_one_result", got_n, 1);
            check("rand_no_dup", out_valid, 0);
        end
        check("rand_total", hs_total, 500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
